uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one UART transmitter among `NUM_REQ` byte producers. It sits in front of the UART TX top level. It arbitrates pending requests, latches the winner's byte, and issues a single-cycle `DATA_VALID` strobe. It then tracks the transmitter's `BUSY` through one complete frame before granting again.

---
 rtl/uart_sched_pkg.sv | 6 +
 rtl/uart_tx_scheduler_rr_arbiter.sv | 22 ++
 rtl/uart_tx_scheduler.sv | 68 ++++++
 tb/tb_uart_tx_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared FSM state encoding and requester-count limits for uart_tx_scheduler
package uart_sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;
  localparam int MIN_REQ = 2;
  localparam int MAX_REQ = 16;
endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first valid requester at or after the pointer
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic               o_any,
  output logic [ID_W-1:0]    o_id
);
  // Scan farthest-first so the candidate nearest the pointer overwrites the rest.
  always_comb begin
    o_any = 1'b0;
    o_id = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
        o_any = 1'b1;
        o_id = ID_W'((int'(i_ptr) + k) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART transmitter among NUM_REQ byte producers
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            REQ_READY,
  input  logic                          TX_BUSY,
  output logic [DATA_WIDTH-1:0]         TX_DATA,
  output logic                          TX_DATA_VALID,
  output logic [ID_W-1:0]               GRANT_ID,
  output logic                          ACTIVE
);
  state_t r_state, w_next;
  logic [ID_W-1:0] r_ptr, r_grant, w_win;
  logic [DATA_WIDTH-1:0] r_data;
  logic w_any, w_take;
  logic [NUM_REQ-1:0] w_one;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .i_req(REQ_VALID),
    .i_ptr(r_ptr),
    .o_any(w_any),
    .o_id (w_win)
  );

  assign w_take = (r_state == IDLE) && w_any && !TX_BUSY;
  assign w_one = {{(NUM_REQ-1){1'b0}}, 1'b1};

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_grant <= '0;
      r_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_data <= REQ_DATA[w_win*DATA_WIDTH +: DATA_WIDTH];
        r_grant <= w_win;
        r_ptr <= (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:       w_next = w_take ? ISSUE : IDLE;
      ISSUE:      w_next = WAIT_START;
      WAIT_START: w_next = TX_BUSY ? WAIT_DONE : WAIT_START;
      WAIT_DONE:  w_next = TX_BUSY ? WAIT_DONE : IDLE;
      default:    w_next = IDLE;
    endcase
  end

  assign TX_DATA = r_data;
  assign GRANT_ID = r_grant;
  assign TX_DATA_VALID = (r_state == ISSUE);
  assign REQ_READY = (r_state == ISSUE) ? (w_one << r_grant) : '0;
  assign ACTIVE = (r_state != IDLE);
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed and randomized checks against a behavioural scheduler model
module tb_uart_tx_scheduler;
  localparam int DW = 8;
  localparam int N = 4;
  localparam int IW = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [N-1:0] REQ_VALID = '0;
  logic [N*DW-1:0] REQ_DATA = '0;
  logic [N-1:0] REQ_READY;
  logic TX_BUSY;
  logic [DW-1:0] TX_DATA;
  logic TX_DATA_VALID;
  logic [IW-1:0] GRANT_ID;
  logic ACTIVE;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tx_cnt = 0;
  int frame_len = 11;
  int mode = 0;
  logic ext_busy = 1'b0;
  logic [N-1:0] keep = '0;

  bit m_free = 1'b1;
  bit m_issue = 1'b0;
  bit m_seen = 1'b0;
  int m_ptr = 0;
  int m_gid = 0;
  logic [DW-1:0] m_data = '0;

  logic s_strobe = 1'b0;
  logic [15:0] snap = '0;
  int q_gid[$];
  int q_cyc[$];
  logic [DW-1:0] q_data[$];
  logic [N-1:0] q_rdy[$];

  assign TX_BUSY = (tx_cnt != 0) || ext_busy;

  always #5 CLK = ~CLK;

  uart_tx_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .CLK(CLK),
    .RST(RST),
    .REQ_VALID(REQ_VALID),
    .REQ_DATA(REQ_DATA),
    .REQ_READY(REQ_READY),
    .TX_BUSY(TX_BUSY),
    .TX_DATA(TX_DATA),
    .TX_DATA_VALID(TX_DATA_VALID),
    .GRANT_ID(GRANT_ID),
    .ACTIVE(ACTIVE)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    REQ_DATA[i*DW +: DW] = v;
  endtask

  // One clock: compare at the falling edge, then advance model/transmitter and drive after the rising edge.
  task automatic tick();
    logic [N-1:0] one;
    logic busy;
    bit found;
    int idx;
    one = 1;
    @(negedge CLK);
    chk("tx_data_valid", TX_DATA_VALID, m_issue);
    chk("req_ready", REQ_READY, m_issue ? (one << m_gid) : '0);
    chk("active", ACTIVE, !m_free);
    chk("grant_id", GRANT_ID, m_gid);
    chk("tx_data", TX_DATA, m_data);
    chk("ready_onehot", $onehot0(REQ_READY), 1);
    s_strobe = TX_DATA_VALID;
    snap = {REQ_READY, TX_DATA_VALID, ACTIVE, GRANT_ID, TX_DATA};
    if (TX_DATA_VALID) begin
      q_gid.push_back(int'(GRANT_ID));
      q_data.push_back(TX_DATA);
      q_rdy.push_back(REQ_READY);
      q_cyc.push_back(cyc);
    end
    @(posedge CLK);
    #1;
    busy = TX_BUSY;
    if (RST) begin
      m_free = 1; m_issue = 0; m_seen = 0; m_ptr = 0; m_gid = 0; m_data = '0;
    end else if (m_issue) begin
      m_issue = 0;
      m_seen = 0;
    end else if (!m_free) begin
      if (!m_seen) m_seen = busy;
      else if (!busy) m_free = 1;
    end else if (!busy && REQ_VALID != '0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && REQ_VALID[idx]) begin
          found = 1;
          m_gid = idx;
          m_data = REQ_DATA[idx*DW +: DW];
          m_ptr = (idx + 1) % N;
        end
      end
      m_issue = 1;
      m_free = 0;
    end
    if (RST) tx_cnt = 0;
    else if (s_strobe) tx_cnt = (mode == 1) ? int'($urandom_range(2, 12)) : frame_len;
    else if (tx_cnt > 0) tx_cnt--;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (mode == 0) begin
        if (REQ_READY[i] && !keep[i]) REQ_VALID[i] = 1'b0;
      end else if (REQ_READY[i]) begin
        REQ_VALID[i] = 1'($urandom_range(0, 1));
        if (REQ_VALID[i]) set_data(i, DW'($urandom));
      end else if (!REQ_VALID[i]) begin
        if ($urandom_range(0, 3) == 0) begin
          REQ_VALID[i] = 1'b1;
          set_data(i, DW'($urandom));
        end
      end else if ($urandom_range(0, 31) == 0) begin
        REQ_VALID[i] = 1'b0;
      end
    end
    if (mode == 1) begin
      if ($urandom_range(0, 15) == 0) ext_busy = !ext_busy;
      RST = ($urandom_range(0, 599) == 0);
    end
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int tgt = q_gid.size() + n;
    int k = 0;
    while (q_gid.size() < tgt && k < budget) begin
      tick();
      k++;
    end
    chk("strobe_timeout", q_gid.size() >= tgt, 1);
  endtask

  task automatic drain();
    int k = 0;
    while (!m_free && k < 200) begin
      tick();
      k++;
    end
    chk("drain_timeout", m_free, 1);
    repeat (2) tick();
  endtask

  initial begin
    int n0;
    int rel;
    repeat (3) tick();
    chk("reset_outputs", snap, 0);
    RST = 1'b0;
    repeat (2) tick();

    // Single request from requester 2
    frame_len = 11;
    n0 = q_gid.size();
    set_data(2, 8'hA5);
    REQ_VALID = 4'b0100;
    wait_strobes(1, 40);
    chk("single_gid", q_gid[n0], 2);
    chk("single_data", q_data[n0], 8'hA5);
    chk("single_ready", q_rdy[n0], 4'b0100);
    drain();
    chk("single_one_strobe", q_gid.size(), n0 + 1);

    // All four continuously requesting after a reset, pointer starts at 0
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int i = 0; i < N; i++) set_data(i, DW'(8'h10 + i));
    keep = 4'hF;
    REQ_VALID = 4'hF;
    n0 = q_gid.size();
    wait_strobes(5, 120);
    keep = '0;
    REQ_VALID = '0;
    for (int i = 0; i < 5; i++) begin
      chk("rr_order", q_gid[n0+i], i % 4);
      chk("rr_data", q_data[n0+i], 8'h10 + (i % 4));
    end
    for (int i = 0; i < 4; i++) chk("rr_gap", q_cyc[n0+i+1] - q_cyc[n0+i] - 1, frame_len + 2);
    drain();

    // Wrap: grant 3, then 1 and 3 pending must go 1 then 3
    n0 = q_gid.size();
    set_data(3, 8'h33);
    REQ_VALID = 4'b1000;
    wait_strobes(1, 40);
    set_data(1, 8'h21);
    set_data(3, 8'h23);
    REQ_VALID = 4'b1010;
    wait_strobes(2, 80);
    chk("wrap_first", q_gid[n0], 3);
    chk("wrap_second", q_gid[n0+1], 1);
    chk("wrap_third", q_gid[n0+2], 3);
    chk("wrap_third_data", q_data[n0+2], 8'h23);
    drain();

    // External busy holds off the grant
    n0 = q_gid.size();
    ext_busy = 1'b1;
    set_data(0, 8'h5A);
    REQ_VALID = 4'b0001;
    repeat (6) tick();
    chk("busy_hold", q_gid.size(), n0);
    ext_busy = 1'b0;
    rel = cyc;
    wait_strobes(1, 10);
    chk("busy_release_latency", q_cyc[n0] - rel, 1);
    chk("busy_release_gid", q_gid[n0], 0);
    drain();

    // Reset in the middle of a frame
    n0 = q_gid.size();
    set_data(2, 8'h77);
    REQ_VALID = 4'b0100;
    wait_strobes(1, 40);
    repeat (4) tick();
    chk("midframe_active", ACTIVE, 1);
    RST = 1'b1;
    set_data(1, 8'h31);
    set_data(3, 8'h3B);
    REQ_VALID = 4'b1010;
    tick();
    RST = 1'b0;
    tick();
    chk("rst_midframe_outputs", snap, 0);
    wait_strobes(2, 80);
    chk("post_rst_gid", q_gid[n0+1], 1);
    chk("post_rst_data", q_data[n0+1], 8'h31);
    chk("post_rst_next_gid", q_gid[n0+2], 3);
    drain();

    // Withdrawal while the transmitter is externally busy
    n0 = q_gid.size();
    ext_busy = 1'b1;
    set_data(1, 8'hEE);
    REQ_VALID = 4'b0010;
    tick();
    REQ_VALID = '0;
    repeat (4) tick();
    ext_busy = 1'b0;
    repeat (20) tick();
    chk("withdraw_no_grant", q_gid.size(), n0);

    // Randomized traffic
    n0 = q_gid.size();
    mode = 1;
    repeat (3000) tick();
    mode = 0;
    RST = 1'b0;
    ext_busy = 1'b0;
    REQ_VALID = '0;
    tick();
    drain();
    chk("random_activity", q_gid.size() > n0 + 50, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
